// File: rtl/sram_arb_pkg.sv
// Shared state encoding and default widths for the SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned SRAM_ADDR_BITS = 16;
  localparam int unsigned SRAM_DATA_BITS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side and sram_iface-side signals of the arbiter; slave is the arbiter view.
interface sram_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned ADDR_BITS = SRAM_ADDR_BITS,
  parameter int unsigned DATA_BITS = SRAM_DATA_BITS
);

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ-1:0]           req_we;
  logic [NUM_REQ*ADDR_BITS-1:0] req_addr;
  logic [NUM_REQ*DATA_BITS-1:0] req_wdata;
  logic [NUM_REQ-1:0]           gnt;
  logic [NUM_REQ-1:0]           done;
  logic [NUM_REQ-1:0]           err;
  logic [DATA_BITS-1:0]         rdata;

  logic                         sram_start;
  logic                         sram_writemode;
  logic [ADDR_BITS-1:0]         sram_addr;
  logic [DATA_BITS-1:0]         sram_wdata;
  logic                         sram_io_done;
  logic [DATA_BITS-1:0]         sram_rdata;

  modport master (
    output req, req_we, req_addr, req_wdata, sram_io_done, sram_rdata,
    input  gnt, done, err, rdata, sram_start, sram_writemode, sram_addr, sram_wdata
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, sram_io_done, sram_rdata,
    output gnt, done, err, rdata, sram_start, sram_writemode, sram_addr, sram_wdata
  );

endinterface

// File: rtl/flex_counter.sv
// Clearable wrapping counter; the registered flag is high in the cycle whose
// increment lands on rollover_val, so a watchdog can act on that same cycle.
module flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic                    count_enable_i,
  input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
  output logic                    rollover_flag_o
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    flag_q, flag_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_enable_i) begin
      count_d = (count_q == rollover_val_i) ? NUM_CNT_BITS'(1)
                                            : count_q + NUM_CNT_BITS'(1);
    end
    flag_d = ((count_d + NUM_CNT_BITS'(1)) == rollover_val_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign rollover_flag_o = flag_q;

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one sram_iface port among NUM_REQ requesters,
// one transaction in flight, with a watchdog abort.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned ADDR_BITS = SRAM_ADDR_BITS,
  parameter int unsigned DATA_BITS = SRAM_DATA_BITS,
  parameter int unsigned TIMEOUT   = 31
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 5;
  localparam logic [NUM_REQ-1:0] REQ_ONE = NUM_REQ'(1);

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic                   we_q, we_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [DATA_BITS-1:0]   wdata_q, wdata_d;
  logic [DATA_BITS-1:0]   rdata_q, rdata_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic [NUM_REQ-1:0]     err_q, err_d;
  logic                   start_q, start_d;

  logic                   pick_vld;
  logic [IDX_W-1:0]       pick_idx;
  logic [31:0]            cand;
  logic                   cnt_flag;
  logic                   timeout;

  // Rotating priority: first requester at or after rr_q, modulo NUM_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(rr_q) + k) % NUM_REQ;
      if (!pick_vld && bus.req[IDX_W'(cand)]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(cand);
      end
    end
  end

  flex_counter #(
    .NUM_CNT_BITS(CNT_W)
  ) u_watchdog (
    .clk            (clk),
    .rst            (rst),
    .clear_i        (state_q == ISSUE),
    .count_enable_i (state_q == WAIT),
    .rollover_val_i (CNT_W'(TIMEOUT)),
    .rollover_flag_o(cnt_flag)
  );

  assign timeout = cnt_flag && (state_q == WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.sram_io_done || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Completion wins over a coincident watchdog expiry.
  always_comb begin
    idx_d   = idx_q;
    rr_d    = rr_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    gnt_d   = '0;
    done_d  = '0;
    err_d   = '0;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          idx_d   = pick_idx;
          we_d    = bus.req_we[pick_idx];
          addr_d  = bus.req_addr[32'(pick_idx) * ADDR_BITS +: ADDR_BITS];
          wdata_d = bus.req_wdata[32'(pick_idx) * DATA_BITS +: DATA_BITS];
          gnt_d   = REQ_ONE << pick_idx;
          start_d = 1'b1;
        end
      end
      ISSUE: gnt_d = REQ_ONE << idx_q;
      WAIT: begin
        if (bus.sram_io_done) begin
          done_d = REQ_ONE << idx_q;
          rr_d   = IDX_W'((32'(idx_q) + 32'd1) % NUM_REQ);
          if (!we_q) rdata_d = bus.sram_rdata;
        end else if (timeout) begin
          err_d = REQ_ONE << idx_q;
          rr_d  = IDX_W'((32'(idx_q) + 32'd1) % NUM_REQ);
        end else begin
          gnt_d = REQ_ONE << idx_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      rr_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end

  assign bus.gnt            = gnt_q;
  assign bus.done           = done_q;
  assign bus.err            = err_q;
  assign bus.rdata          = rdata_q;
  assign bus.sram_start     = start_q;
  assign bus.sram_writemode = we_q;
  assign bus.sram_addr      = addr_q;
  assign bus.sram_wdata     = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter (NUM_REQ=3, TIMEOUT=31).
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  sram_arbiter_if #(.NUM_REQ(3), .ADDR_BITS(16), .DATA_BITS(32)) bus ();

  sram_arbiter #(
    .NUM_REQ(3), .ADDR_BITS(16), .DATA_BITS(32), .TIMEOUT(31)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic wait_start(output int lat);
    lat = -1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (bus.sram_start === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.sram_io_done = 1'b0; bus.sram_rdata = '0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.gnt !== 3'b000 || bus.done !== 3'b000 || bus.err !== 3'b000) begin
      bad++; $display("FAIL reset_ctl gnt=%b done=%b err=%b expected 000/000/000", bus.gnt, bus.done, bus.err);
    end
    total++;
    if (bus.sram_start !== 1'b0 || bus.sram_writemode !== 1'b0) begin
      bad++; $display("FAIL reset_strobe start=%b we=%b expected 0/0", bus.sram_start, bus.sram_writemode);
    end
    total++;
    if (bus.sram_addr !== 16'h0 || bus.sram_wdata !== 32'h0 || bus.rdata !== 32'h0) begin
      bad++; $display("FAIL reset_data addr=%h wdata=%h rdata=%h expected 0", bus.sram_addr, bus.sram_wdata, bus.rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.gnt !== 3'b000 || bus.sram_start !== 1'b0) begin
      bad++; $display("FAIL idle_no_req gnt=%b start=%b expected 000/0", bus.gnt, bus.sram_start);
    end
  endtask

  task automatic test_contention();
    int lat;
    logic [2:0]  exp_g;
    logic [15:0] exp_a;
    bus.req = 3'b111; bus.req_we = 3'b000;
    bus.req_addr = {16'h0102, 16'h0101, 16'h0100};
    for (int t = 0; t < 4; t++) begin
      exp_g = 3'b001 << (t % 3);
      exp_a = 16'h0100 + 16'(t % 3);
      wait_start(lat);
      total++;
      if (lat !== 1) begin
        bad++; $display("FAIL rr_start_lat t=%0d got=%0d expected 1", t, lat);
      end
      total++;
      if (bus.gnt !== exp_g) begin
        bad++; $display("FAIL rr_order t=%0d gnt=%b expected %b", t, bus.gnt, exp_g);
      end
      total++;
      if (bus.sram_addr !== exp_a) begin
        bad++; $display("FAIL rr_addr t=%0d addr=%h expected %h", t, bus.sram_addr, exp_a);
      end
      @(negedge clk);
      total++;
      if (bus.sram_start !== 1'b0 || bus.gnt !== exp_g) begin
        bad++; $display("FAIL rr_single_start t=%0d start=%b gnt=%b expected 0/%b", t, bus.sram_start, bus.gnt, exp_g);
      end
      bus.sram_io_done = 1'b1;
      bus.sram_rdata   = 32'hA000_0000 + 32'(t);
      @(negedge clk);
      total++;
      if (bus.done !== exp_g || bus.gnt !== 3'b000 || bus.sram_start !== 1'b0) begin
        bad++; $display("FAIL rr_done t=%0d done=%b gnt=%b start=%b expected %b/000/0", t, bus.done, bus.gnt, bus.sram_start, exp_g);
      end
      total++;
      if (bus.rdata !== 32'hA000_0000 + 32'(t)) begin
        bad++; $display("FAIL rr_rdata t=%0d rdata=%h expected %h", t, bus.rdata, 32'hA000_0000 + 32'(t));
      end
      bus.sram_io_done = 1'b0;
      if (t == 3) bus.req = 3'b000;
    end
    @(negedge clk);
    total++;
    if (bus.done !== 3'b000 || bus.sram_start !== 1'b0) begin
      bad++; $display("FAIL rr_quiesce done=%b start=%b expected 000/0", bus.done, bus.sram_start);
    end
  endtask

  task automatic test_single_read();
    int lat;
    bit quiet;
    bus.req = 3'b010; bus.req_we = 3'b000;
    bus.req_addr = {16'h0000, 16'h0040, 16'h0000};
    wait_start(lat);
    total++;
    if (lat !== 1 || bus.gnt !== 3'b010) begin
      bad++; $display("FAIL rd_grant lat=%0d gnt=%b expected 1/010", lat, bus.gnt);
    end
    total++;
    if (bus.sram_addr !== 16'h0040 || bus.sram_writemode !== 1'b0) begin
      bad++; $display("FAIL rd_addr addr=%h we=%b expected 0040/0", bus.sram_addr, bus.sram_writemode);
    end
    quiet = 1'b1;
    repeat (11) begin
      @(negedge clk);
      if (bus.done !== 3'b000 || bus.err !== 3'b000 || bus.gnt !== 3'b010) quiet = 1'b0;
    end
    total++;
    if (quiet !== 1'b1) begin
      bad++; $display("FAIL rd_wait_quiet got=0 expected 1");
    end
    bus.sram_io_done = 1'b1; bus.sram_rdata = 32'hDEADBEEF;
    @(negedge clk);
    total++;
    if (bus.done !== 3'b010 || bus.rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL rd_done done=%b rdata=%h expected 010/deadbeef", bus.done, bus.rdata);
    end
    bus.sram_io_done = 1'b0; bus.sram_rdata = 32'h0; bus.req = 3'b000;
    @(negedge clk);
    total++;
    if (bus.done !== 3'b000 || bus.rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL rd_pulse done=%b rdata=%h expected 000/deadbeef", bus.done, bus.rdata);
    end
  endtask

  task automatic test_write_hold();
    int lat;
    bit stable;
    bus.req = 3'b100; bus.req_we = 3'b100;
    bus.req_addr  = {16'hFFFF, 16'h0000, 16'h0000};
    bus.req_wdata = {32'h12345678, 32'h0, 32'h0};
    wait_start(lat);
    total++;
    if (lat !== 1 || bus.gnt !== 3'b100 || bus.sram_writemode !== 1'b1) begin
      bad++; $display("FAIL wr_grant lat=%0d gnt=%b we=%b expected 1/100/1", lat, bus.gnt, bus.sram_writemode);
    end
    total++;
    if (bus.sram_addr !== 16'hFFFF || bus.sram_wdata !== 32'h12345678) begin
      bad++; $display("FAIL wr_operands addr=%h wdata=%h expected ffff/12345678", bus.sram_addr, bus.sram_wdata);
    end
    bus.req_addr = '0; bus.req_wdata = '0;
    stable = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.sram_addr !== 16'hFFFF || bus.sram_wdata !== 32'h12345678 ||
          bus.sram_writemode !== 1'b1 || bus.gnt !== 3'b100) stable = 1'b0;
    end
    total++;
    if (stable !== 1'b1) begin
      bad++; $display("FAIL wr_stable got=0 expected 1");
    end
    bus.sram_io_done = 1'b1; bus.sram_rdata = 32'h55555555;
    @(negedge clk);
    total++;
    if (bus.done !== 3'b100 || bus.rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL wr_done done=%b rdata=%h expected 100/deadbeef", bus.done, bus.rdata);
    end
    total++;
    if (bus.sram_addr !== 16'hFFFF || bus.sram_wdata !== 32'h12345678 || bus.sram_writemode !== 1'b1) begin
      bad++; $display("FAIL wr_hold_done addr=%h wdata=%h we=%b expected ffff/12345678/1", bus.sram_addr, bus.sram_wdata, bus.sram_writemode);
    end
    bus.sram_io_done = 1'b0; bus.req = 3'b000; bus.req_we = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat;
    int hit;
    bus.req = 3'b001; bus.req_we = 3'b000;
    bus.req_addr = {16'h0000, 16'h0000, 16'h0010};
    wait_start(lat);
    total++;
    if (lat !== 1 || bus.gnt !== 3'b001) begin
      bad++; $display("FAIL to_grant lat=%0d gnt=%b expected 1/001", lat, bus.gnt);
    end
    hit = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.err !== 3'b000 || bus.done !== 3'b000) begin
        hit = n;
        break;
      end
    end
    bus.req = 3'b000;
    total++;
    if (hit !== 32) begin
      bad++; $display("FAIL to_latency cycles=%0d expected 32", hit);
    end
    total++;
    if (bus.err !== 3'b001 || bus.done !== 3'b000 || bus.rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL to_err err=%b done=%b rdata=%h expected 001/000/deadbeef", bus.err, bus.done, bus.rdata);
    end
    @(negedge clk);
    total++;
    if (bus.err !== 3'b000 || bus.gnt !== 3'b000) begin
      bad++; $display("FAIL to_pulse err=%b gnt=%b expected 000/000", bus.err, bus.gnt);
    end
  endtask

  task automatic test_done_at_limit();
    int lat;
    bit quiet;
    bus.req = 3'b011; bus.req_we = 3'b000;
    bus.req_addr = {16'h0000, 16'h0021, 16'h0020};
    wait_start(lat);
    total++;
    if (lat !== 1 || bus.gnt !== 3'b010) begin
      bad++; $display("FAIL rr_after_timeout lat=%0d gnt=%b expected 1/010", lat, bus.gnt);
    end
    quiet = 1'b1;
    repeat (31) begin
      @(negedge clk);
      if (bus.err !== 3'b000 || bus.done !== 3'b000) quiet = 1'b0;
    end
    total++;
    if (quiet !== 1'b1) begin
      bad++; $display("FAIL lim_quiet got=0 expected 1");
    end
    bus.sram_io_done = 1'b1; bus.sram_rdata = 32'hCAFEF00D;
    @(negedge clk);
    total++;
    if (bus.done !== 3'b010 || bus.err !== 3'b000 || bus.rdata !== 32'hCAFEF00D) begin
      bad++; $display("FAIL lim_priority done=%b err=%b rdata=%h expected 010/000/cafef00d", bus.done, bus.err, bus.rdata);
    end
    bus.sram_io_done = 1'b0; bus.req = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_early_drop();
    int lat;
    bit held;
    bit quiet;
    bus.req = 3'b001; bus.req_we = 3'b000;
    bus.req_addr = {16'h0000, 16'h0000, 16'h0077};
    wait_start(lat);
    total++;
    if (lat !== 1 || bus.gnt !== 3'b001 || bus.sram_addr !== 16'h0077) begin
      bad++; $display("FAIL drop_grant lat=%0d gnt=%b addr=%h expected 1/001/0077", lat, bus.gnt, bus.sram_addr);
    end
    @(negedge clk);
    bus.req = 3'b000;
    held = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.gnt !== 3'b001 || bus.done !== 3'b000) held = 1'b0;
    end
    total++;
    if (held !== 1'b1) begin
      bad++; $display("FAIL drop_held got=0 expected 1");
    end
    bus.sram_io_done = 1'b1; bus.sram_rdata = 32'h0BADCAFE;
    @(negedge clk);
    total++;
    if (bus.done !== 3'b001 || bus.rdata !== 32'h0BADCAFE) begin
      bad++; $display("FAIL drop_done done=%b rdata=%h expected 001/0badcafe", bus.done, bus.rdata);
    end
    bus.sram_rdata = 32'hFFFFFFFF;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.done !== 3'b000 || bus.err !== 3'b000 || bus.gnt !== 3'b000 ||
          bus.sram_start !== 1'b0 || bus.rdata !== 32'h0BADCAFE) quiet = 1'b0;
    end
    total++;
    if (quiet !== 1'b1) begin
      bad++; $display("FAIL spurious_io_done got=0 expected 1");
    end
    bus.sram_io_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    bus.req = 3'b100; bus.req_we = 3'b000;
    bus.req_addr = {16'h0300, 16'h0200, 16'h0100};
    wait_start(lat);
    total++;
    if (lat !== 1 || bus.gnt !== 3'b100) begin
      bad++; $display("FAIL mid_grant lat=%0d gnt=%b expected 1/100", lat, bus.gnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (bus.gnt !== 3'b000 || bus.sram_start !== 1'b0 || bus.sram_addr !== 16'h0 ||
        bus.rdata !== 32'h0 || bus.sram_writemode !== 1'b0) begin
      bad++; $display("FAIL mid_reset_out gnt=%b start=%b addr=%h rdata=%h we=%b expected all 0",
                      bus.gnt, bus.sram_start, bus.sram_addr, bus.rdata, bus.sram_writemode);
    end
    bus.req = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.done !== 3'b000 || bus.err !== 3'b000) begin
      bad++; $display("FAIL mid_no_done done=%b err=%b expected 000/000", bus.done, bus.err);
    end
    bus.req = 3'b111;
    wait_start(lat);
    total++;
    if (lat !== 1 || bus.gnt !== 3'b001 || bus.sram_addr !== 16'h0100) begin
      bad++; $display("FAIL mid_rr_restart lat=%0d gnt=%b addr=%h expected 1/001/0100", lat, bus.gnt, bus.sram_addr);
    end
    bus.req = 3'b000;
    bus.sram_io_done = 1'b1; bus.sram_rdata = 32'h00C0FFEE;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.done !== 3'b001 || bus.rdata !== 32'h00C0FFEE) begin
      bad++; $display("FAIL mid_after_done done=%b rdata=%h expected 001/00c0ffee", bus.done, bus.rdata);
    end
    bus.sram_io_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_read();
    test_write_hold();
    test_timeout();
    test_done_at_limit();
    test_early_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single `sram_iface` transaction port between `NUM_REQ` requesters (pixel fetch, result write-back, host access) in the edge-detector datapath. It uses round-robin arbitration, one outstanding SRAM transaction at a time, and a watchdog timeout. It sits between the requester blocks and `sram_iface`, driving that block's `start`/`writemode`/address/data inputs and consuming its `io_done`/read data.

## Interface
- `NUM_REQ`, 3: number of requesters (2..4).
- `ADDR_BITS`, 16: SRAM word address width.
- `DATA_BITS`, 32: SRAM data width.
- `TIMEOUT`, 31: maximum WAIT cycles before abort (fits 5 bits).

- `clk` in 1: sole clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in NUM_REQ: per-requester request level.
- `req_we` in NUM_REQ: per-requester write (1) / read (0).
- `req_addr` in NUM_REQ*ADDR_BITS: packed, requester i at slice i.
- `req_wdata` in NUM_REQ*DATA_BITS: packed write data.
- `gnt` out NUM_REQ: one-hot, requester owns the SRAM.
- `done` out NUM_REQ: one-cycle completion pulse.
- `err` out NUM_REQ: one-cycle timeout pulse.
- `rdata` out DATA_BITS: last read data, valid with `done`.
- `sram_start` out 1: one-cycle strobe to `sram_iface`.
- `sram_writemode` out 1: 1 write, 0 read.
- `sram_addr` out ADDR_BITS: held for the whole transaction.
- `sram_wdata` out DATA_BITS: held for the whole transaction.
- `sram_io_done` in 1: completion from `sram_iface`.
- `sram_rdata` in DATA_BITS: read data, valid when `sram_io_done`=1.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE:** if any `req` bit is set, pick the first set bit at or after `rr_ptr` (modulo NUM_REQ). Latch index, `req_we`, `req_addr` and `req_wdata` into registers, then go to ISSUE. With no request, stay in IDLE.
- **ISSUE:** `sram_start`=1 for exactly this cycle, then go to WAIT. Clear the timeout counter.
- **WAIT:** the timeout counter increments each cycle.
  - If `sram_io_done`=1: register `sram_rdata` into `rdata` (reads only; writes leave `rdata` unchanged). Pulse `done[idx]` next cycle, set `rr_ptr` to idx+1 mod NUM_REQ, and go to IDLE.
  - Else, if the counter reaches TIMEOUT: pulse `err[idx]` next cycle, set `rr_ptr` to idx+1, and go to IDLE. `rdata` is unchanged.
  - `sram_io_done` takes priority over timeout in the same cycle.
- **Outputs:**
  - `gnt[idx]`=1 in ISSUE and WAIT; `gnt`=0 in IDLE.
  - `sram_writemode`, `sram_addr` and `sram_wdata` come from the latched registers and are stable from ISSUE through the `done`/`err` cycle.
- **Request sampling:** `req` is sampled only in IDLE. Dropping `req` while granted does not abort; the transaction completes and still pulses `done`. Requesters hold `req` and operands until `done`/`err`.
- **`sram_io_done` outside WAIT:** ignored.
- **Reset mid-transaction:** abandons the transaction with no `done`/`err`.
- **Reset values:** state IDLE, `rr_ptr`=0, `gnt`=0, `done`=0, `err`=0, `rdata`=0, `sram_start`=0, `sram_writemode`=0, `sram_addr`=0, `sram_wdata`=0.

## Timing
- Request seen in IDLE at edge 0 → ISSUE and `sram_start` high in cycle 1 → WAIT from cycle 2.
- `sram_io_done` high in cycle k → `done` and `rdata` valid in cycle k+1. The state is IDLE in k+1.
- Back-to-back grants: the next `sram_start` comes no earlier than cycle k+2, so there is one dead IDLE cycle between transactions.
- A timeout asserts `err` TIMEOUT+1 cycles after ISSUE.
- Fairness: with all requesters active continuously, grants rotate 0,1,2,0,… No requester waits more than NUM_REQ-1 transactions.

## Structure
- Package `sram_arb_pkg` holds:
  - the `arb_state_t` enum {IDLE, ISSUE, WAIT};
  - default width constants (`SRAM_ADDR_BITS`=16, `SRAM_DATA_BITS`=32).
- Sub-module: one `flex_counter` instance (NUM_CNT_BITS=5, rollover_val=TIMEOUT) for the watchdog. It is cleared in ISSUE and enabled in WAIT; its `rollover_flag` is the timeout.
- Round-robin pick is a combinational priority rotate inside the module; no extra sub-module.

## Test plan
- **Reset:** assert `rst` mid-WAIT → all outputs 0, no `done`, and the next request is granted from index 0.
- **Single read:** `req`=3'b010, addr 16'h0040. `sram_io_done` arrives 12 cycles after start with data 32'hDEADBEEF → `done`=3'b010 for one cycle, `rdata`=32'hDEADBEEF.
- **Contention:** `req`=3'b111 held continuously → grant order 0,1,2,0. Each `sram_start` is a single cycle, separated by one IDLE cycle after `done`.
- **Write hold:** requester 2 writes 32'h12345678 to 16'hFFFF → `sram_writemode`=1 and `sram_addr`/`sram_wdata` stable from ISSUE until `done`. `rdata` keeps its previous value.
- **Timeout:** never assert `sram_io_done` → `err[idx]` pulses 32 cycles after ISSUE and `rr_ptr` advances. A simultaneous `io_done` at the limit produces `done`, not `err`.
- **Early request drop:** requester 0 drops `req` one cycle after grant → transaction still completes and `done[0]` pulses. A spurious `sram_io_done` in IDLE is ignored.
